// File: rtl/sia_rx_ctl.sv
// SIA receive-side controller: receiver configuration, frame capture into a small FIFO,
// and a 16-bit Wishbone B4 pipelined slave with status and a level interrupt.
module sia_rx_ctl #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] BAUD_RESET = 32'd868
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [2:0]  adr_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        irq_o,
    output logic        rx_reset_o,
    output logic [5:0]  bits_o,
    output logic [31:0] baud_o,
    output logic        eedd_o,
    output logic        eedc_o,
    input  logic [15:0] rx_dat_i,
    input  logic        rx_idle_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [15:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovr_q, ovr_d;
    logic [5:0]      bits_q, bits_d;
    logic            eedd_q, eedd_d, eedc_q, eedc_d, irq_en_q, irq_en_d, rx_en_q, rx_en_d;
    logic [31:0]     baud_q, baud_d;
    logic            idle_q, rx_reset_q, ack_q;
    logic [15:0]     dat_q, rdata;

    logic        req, wr, rd, empty, full, frame_end, push, pop;
    logic [4:0]  shamt;
    logic [4:0]  cnt5;
    logic [15:0] word;

    assign req       = cyc_i & stb_i;
    assign wr        = req & we_i;
    assign rd        = req & ~we_i;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(DEPTH));
    assign frame_end = rx_idle_i & ~idle_q & rx_en_q;
    assign pop       = rd & (adr_i == 3'd0) & ~empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO is still legal.
    assign push      = frame_end & (~full | pop);
    assign cnt5      = 5'(count_q);

    // Right-justify the frame; out-of-range lengths pass the shift register through as-is.
    assign shamt = 5'(6'd16 - bits_q);
    assign word  = ((bits_q != 6'd0) && (bits_q <= 6'd16)) ? (rx_dat_i >> shamt) : rx_dat_i;

    always_comb begin
        rdata = 16'h0000;
        unique case (adr_i)
            3'd0:    rdata = empty ? 16'h0000 : mem_q[rptr_q];
            3'd1:    rdata = {7'b0, cnt5, rx_idle_i, ovr_q, full, ~empty};
            3'd2:    rdata = {rx_en_q, irq_en_q, 4'b0, eedc_q, eedd_q, 2'b0, bits_q};
            3'd3:    rdata = baud_q[15:0];
            3'd4:    rdata = baud_q[31:16];
            default: rdata = 16'h0000;
        endcase
    end

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        bits_d   = bits_q;
        eedd_d   = eedd_q;
        eedc_d   = eedc_q;
        irq_en_d = irq_en_q;
        rx_en_d  = rx_en_q;
        baud_d   = baud_q;
        if (push) wptr_d = wptr_q + PtrW'(1);
        if (pop)  rptr_d = rptr_q + PtrW'(1);
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (pop && !push) count_d = count_q - CntW'(1);
        if (wr) begin
            unique case (adr_i)
                3'd1: if (dat_i[2]) ovr_d = 1'b0;
                3'd2: begin
                    bits_d   = dat_i[5:0];
                    eedd_d   = dat_i[8];
                    eedc_d   = dat_i[9];
                    irq_en_d = dat_i[14];
                    rx_en_d  = dat_i[15];
                end
                3'd3:    baud_d[15:0]  = dat_i;
                3'd4:    baud_d[31:16] = dat_i;
                default: ;
            endcase
        end
        // A new drop wins over a simultaneous clear.
        if (frame_end && !push) ovr_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            bits_q     <= 6'd0;
            eedd_q     <= 1'b0;
            eedc_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            rx_en_q    <= 1'b0;
            baud_q     <= BAUD_RESET;
            idle_q     <= 1'b1;
            rx_reset_q <= 1'b1;
            ack_q      <= 1'b0;
            dat_q      <= 16'h0000;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            bits_q     <= bits_d;
            eedd_q     <= eedd_d;
            eedc_q     <= eedc_d;
            irq_en_q   <= irq_en_d;
            rx_en_q    <= rx_en_d;
            baud_q     <= baud_d;
            idle_q     <= rx_idle_i;
            rx_reset_q <= ~rx_en_q;
            ack_q      <= req;
            dat_q      <= rd ? rdata : 16'h0000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= word;
    end

    assign dat_o      = ack_q ? dat_q : 16'h0000;
    assign ack_o      = ack_q;
    assign stall_o    = 1'b0;
    assign irq_o      = irq_en_q & (~empty | ovr_q);
    assign rx_reset_o = rx_reset_q;
    assign bits_o     = bits_q;
    assign baud_o     = baud_q;
    assign eedd_o     = eedd_q;
    assign eedc_o     = eedc_q;

endmodule

// File: tb/tb_sia_rx_ctl.sv
// Directed bench for sia_rx_ctl: read data is scoreboarded at request time and
// compared when the acknowledge returns.
module tb_sia_rx_ctl;

    localparam int unsigned DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [2:0]  adr_i = 3'd0;
    logic [15:0] dat_i = 16'h0;
    logic [15:0] dat_o;
    logic        ack_o, stall_o, irq_o, rx_reset_o, eedd_o, eedc_o;
    logic [5:0]  bits_o;
    logic [31:0] baud_o;
    logic [15:0] rx_dat_i = 16'h0;
    logic        rx_idle_i = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    sia_rx_ctl #(.DEPTH(DEPTH), .BAUD_RESET(32'd868)) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .ack_o     (ack_o),
        .stall_o   (stall_o),
        .irq_o     (irq_o),
        .rx_reset_o(rx_reset_o),
        .bits_o    (bits_o),
        .baud_o    (baud_o),
        .eedd_o    (eedd_o),
        .eedc_o    (eedc_o),
        .rx_dat_i  (rx_dat_i),
        .rx_idle_i (rx_idle_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the returned word against the scoreboard head once an ack is seen.
    task automatic take_ack(input string tag, input logic is_read);
        int n = 0;
        logic [15:0] e;
        while (ack_o !== 1'b1 && n < 4) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({tag, "_ack_latency"}, n, 0);
        if (is_read && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (ack_o === 1'b1) chk(tag, {16'h0, dat_o}, {16'h0, e});
        end
        @(posedge clk_i); #1;
        chk({tag, "_ack_single"}, {31'h0, ack_o}, 0);
        chk({tag, "_dat_idle"}, {16'h0, dat_o}, 0);
    endtask

    task automatic bus(input logic w, input logic [2:0] a, input logic [15:0] d,
                       input logic [15:0] exp, input string tag);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        if (!w) exp_q.push_back(exp);
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        take_ack(tag, !w);
    endtask

    task automatic frame(input logic [15:0] d);
        @(negedge clk_i); rx_dat_i = d; rx_idle_i = 1'b0;
        @(negedge clk_i); rx_idle_i = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) reset_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_rx_reset", {31'h0, rx_reset_o}, 1);
        chk("rst_baud", baud_o, 868);
        chk("rst_ack", {31'h0, ack_o}, 0);
        chk("rst_irq", {31'h0, irq_o}, 0);
        chk("rst_stall", {31'h0, stall_o}, 0);
        bus(1'b0, 3'd1, 16'h0, 16'h0008, "rst_status");
        bus(1'b0, 3'd2, 16'h0, 16'h0000, "rst_config");

        // Configuration; rx_reset_o lags the CONFIG write by one cycle
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd2; dat_i = 16'hC308;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        chk("cfg_bits", {26'h0, bits_o}, 8);
        chk("cfg_edges", {30'h0, eedc_o, eedd_o}, 2'b11);
        chk("cfg_rx_reset_hold", {31'h0, rx_reset_o}, 1);
        chk("cfg_ack", {31'h0, ack_o}, 1);
        @(posedge clk_i); #1;
        chk("cfg_rx_reset_fall", {31'h0, rx_reset_o}, 0);
        chk("cfg_ack_single", {31'h0, ack_o}, 0);
        bus(1'b1, 3'd2, 16'hC008, 16'h0, "cfg_write");
        bus(1'b1, 3'd3, 16'h0010, 16'h0, "baudl_write");
        bus(1'b1, 3'd4, 16'h0000, 16'h0, "baudh_write");
        chk("cfg_baud", baud_o, 16);
        bus(1'b0, 3'd2, 16'h0, 16'hC008, "cfg_read");
        bus(1'b0, 3'd3, 16'h0, 16'h0010, "baudl_read");

        // Justification
        frame(16'hA5FF);
        bus(1'b0, 3'd1, 16'h0, 16'h0019, "just_status");
        chk("just_irq", {31'h0, irq_o}, 1);
        bus(1'b0, 3'd0, 16'h0, 16'h00A5, "just_rxdata");
        bus(1'b0, 3'd1, 16'h0, 16'h0008, "just_status_after");
        chk("just_irq_clear", {31'h0, irq_o}, 0);
        bus(1'b1, 3'd2, 16'hC00C, 16'h0, "cfg_bits12");
        frame(16'hABCD);
        bus(1'b0, 3'd0, 16'h0, 16'h0ABC, "just_bits12");
        bus(1'b1, 3'd2, 16'hC010, 16'h0, "cfg_bits16");
        frame(16'hBEEF);
        bus(1'b0, 3'd0, 16'h0, 16'hBEEF, "just_bits16");
        bus(1'b1, 3'd2, 16'hC014, 16'h0, "cfg_bits20");
        frame(16'h1234);
        bus(1'b0, 3'd0, 16'h0, 16'h1234, "just_bits20");
        bus(1'b1, 3'd2, 16'hC008, 16'h0, "cfg_bits8");

        // Overrun: DEPTH+1 frames, no reads
        for (int i = 0; i < DEPTH + 1; i++) frame(16'((i + 1) * 16'h1100 + 16'h0033));
        bus(1'b0, 3'd1, 16'h0, 16'h004F, "ovr_status");
        for (int i = 0; i < DEPTH; i++) bus(1'b0, 3'd0, 16'h0, 16'((i + 1) * 16'h0011), "ovr_word");
        bus(1'b0, 3'd1, 16'h0, 16'h000C, "ovr_sticky");
        chk("ovr_irq", {31'h0, irq_o}, 1);
        bus(1'b1, 3'd1, 16'h0004, 16'h0, "ovr_w1c");
        bus(1'b0, 3'd1, 16'h0, 16'h0008, "ovr_cleared");
        chk("ovr_irq_clear", {31'h0, irq_o}, 0);

        // Simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) frame(16'((i + 1) << 8));
        @(negedge clk_i); rx_dat_i = 16'h0500; rx_idle_i = 1'b0;
        @(negedge clk_i); rx_idle_i = 1'b1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd0;
        exp_q.push_back(16'h0001);
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        take_ack("sim_pop", 1'b1);
        bus(1'b0, 3'd1, 16'h0, 16'h004B, "sim_status");
        for (int i = 2; i <= DEPTH + 1; i++) bus(1'b0, 3'd0, 16'h0, 16'(i), "sim_drain");

        // Empty and unmapped
        bus(1'b0, 3'd0, 16'h0, 16'h0000, "empty_rxdata");
        bus(1'b0, 3'd1, 16'h0, 16'h0008, "empty_status");
        bus(1'b0, 3'd6, 16'h0, 16'h0000, "unmapped_read");
        bus(1'b1, 3'd7, 16'hFFFF, 16'h0, "unmapped_write");
        bus(1'b0, 3'd2, 16'h0, 16'hC008, "unmapped_no_effect");

        // Frames ignored while disabled
        bus(1'b1, 3'd2, 16'h0008, 16'h0, "cfg_disable");
        frame(16'h7700);
        chk("dis_rx_reset", {31'h0, rx_reset_o}, 1);
        bus(1'b0, 3'd1, 16'h0, 16'h0008, "dis_status");

        // Reset mid-transfer
        bus(1'b1, 3'd2, 16'hC008, 16'h0, "cfg_reenable");
        frame(16'h7700);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd0;
        #2 reset_ni = 1'b0;
        @(posedge clk_i); #1;
        chk("mid_rst_ack", {31'h0, ack_o}, 0);
        chk("mid_rst_irq", {31'h0, irq_o}, 0);
        chk("mid_rst_rx_reset", {31'h0, rx_reset_o}, 1);
        chk("mid_rst_baud", baud_o, 868);
        @(negedge clk_i); cyc_i = 1'b0; stb_i = 1'b0; reset_ni = 1'b1;
        bus(1'b0, 3'd1, 16'h0, 16'h0008, "mid_rst_status");
        bus(1'b0, 3'd2, 16'h0, 16'h0000, "mid_rst_config");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
